// File: rtl/l1_prefetch_arbiter_if.sv
// Bundle of the demand, prefetcher and cache request channels of l1_prefetch_arbiter.
// master = requester/cache side (drives demand, prefetch and mem ready); slave = the arbiter.
interface l1_prefetch_arbiter_if #(
    parameter int ADDR_BITS = 40,
    parameter int TAG_BITS  = 8,
    parameter int CMD_BITS  = 5
);
    // Every channel is valid/ready: a transfer happens in a cycle where both are high;
    // valid and its payload stay stable until that cycle.
    logic                 cpu_req_valid;
    logic                 cpu_req_ready;
    logic [ADDR_BITS-1:0] cpu_req_bits_addr;
    logic [TAG_BITS-1:0]  cpu_req_bits_tag;
    logic [CMD_BITS-1:0]  cpu_req_bits_cmd;

    logic                 pf_valid;
    logic                 pf_ready;
    logic [ADDR_BITS-1:0] pf_bits_addr;
    logic                 pf_bits_write;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ADDR_BITS-1:0] mem_req_bits_addr;
    logic [TAG_BITS-1:0]  mem_req_bits_tag;
    logic [CMD_BITS-1:0]  mem_req_bits_cmd;
    logic                 mem_req_is_prefetch;

    logic                 stat_pf_issued;
    logic                 stat_pf_dropped;

    modport master (
        output cpu_req_valid, cpu_req_bits_addr, cpu_req_bits_tag, cpu_req_bits_cmd,
        output pf_valid, pf_bits_addr, pf_bits_write, mem_req_ready,
        input  cpu_req_ready, pf_ready, mem_req_valid, mem_req_bits_addr,
        input  mem_req_bits_tag, mem_req_bits_cmd, mem_req_is_prefetch,
        input  stat_pf_issued, stat_pf_dropped
    );

    modport slave (
        input  cpu_req_valid, cpu_req_bits_addr, cpu_req_bits_tag, cpu_req_bits_cmd,
        input  pf_valid, pf_bits_addr, pf_bits_write, mem_req_ready,
        output cpu_req_ready, pf_ready, mem_req_valid, mem_req_bits_addr,
        output mem_req_bits_tag, mem_req_bits_cmd, mem_req_is_prefetch,
        output stat_pf_issued, stat_pf_dropped
    );
endinterface

// File: rtl/l1_prefetch_arbiter.sv
// Shares the L1 request port between demand requests and deduplicated, line-aligned prefetches.
// Optional: define L1_PREFETCH_DEMAND_FILTER_EN to cancel queued prefetches hit by a demand.
module l1_prefetch_arbiter #(
    parameter int ADDR_BITS    = 40,
    parameter int TAG_BITS     = 8,
    parameter int CMD_BITS     = 5,
    parameter int LINE_SHIFT   = 6,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 16,
    parameter logic [TAG_BITS-1:0] PF_TAG = 8'hFF
) (
    input logic clock,
    input logic reset,
    l1_prefetch_arbiter_if.slave bus
);
    localparam int LINE_BITS = ADDR_BITS - LINE_SHIFT;
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int STV_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [STV_W-1:0]    LIMIT_C = STV_W'(STARVE_LIMIT);
    localparam logic [CMD_BITS-1:0] M_PFR   = CMD_BITS'(5'b00010);
    localparam logic [CMD_BITS-1:0] M_PFW   = CMD_BITS'(5'b00011);

    logic [LINE_BITS-1:0]   line_q [QUEUE_DEPTH];
    logic [LINE_BITS-1:0]   line_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] wr_q, wr_d, vld_q, vld_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STV_W-1:0]       starve_q, starve_d;
    logic                   issued_q, issued_d, dropped_q, dropped_d;

    logic                 full, head_alloc, head_valid, pf_sel, mem_valid;
    logic                 pf_hs, dup, enq, issue, deq, filt_hit;
    logic [LINE_BITS-1:0] pf_line;

    always_comb begin
        full       = (cnt_q == DEPTH_C);
        head_alloc = (cnt_q != '0);
        head_valid = head_alloc && vld_q[head_q];
        pf_sel     = head_valid && (!bus.cpu_req_valid || starve_q == LIMIT_C);
        mem_valid  = bus.cpu_req_valid || head_valid;
        pf_line    = bus.pf_bits_addr[ADDR_BITS-1:LINE_SHIFT];
        dup = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (vld_q[i] && line_q[i] == pf_line) dup = 1'b1;
        end
        pf_hs = bus.pf_valid && !full;
        enq   = pf_hs && !dup;
        issue = mem_valid && bus.mem_req_ready && pf_sel;
        // A cancelled head is retired without ever reaching the mem port.
        deq   = issue || (head_alloc && !head_valid);
    end

`ifdef L1_PREFETCH_DEMAND_FILTER_EN
    logic                 cpu_hs;
    logic [LINE_BITS-1:0] cpu_line;
    assign cpu_hs   = bus.cpu_req_valid && !pf_sel && bus.mem_req_ready;
    assign cpu_line = bus.cpu_req_bits_addr[ADDR_BITS-1:LINE_SHIFT];
`endif

    always_comb begin
        line_d   = line_q;
        wr_d     = wr_q;
        vld_d    = vld_q;
        filt_hit = 1'b0;
`ifdef L1_PREFETCH_DEMAND_FILTER_EN
        if (cpu_hs) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (vld_q[i] && line_q[i] == cpu_line) begin
                    vld_d[i] = 1'b0;
                    filt_hit = 1'b1;
                end
            end
        end
`endif
        if (deq) vld_d[head_q] = 1'b0;
        if (enq) begin
            line_d[tail_q] = pf_line;
            wr_d[tail_q]   = bus.pf_bits_write;
            vld_d[tail_q]  = 1'b1;
        end
        head_d = deq ? head_q + PTR_W'(1) : head_q;
        tail_d = enq ? tail_q + PTR_W'(1) : tail_q;
        unique case ({enq, deq})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // Counts only demand-won cycles with a live prefetch waiting; holds while a forced grant stalls.
        if (issue || !head_valid)
            starve_d = '0;
        else if (bus.cpu_req_valid && !pf_sel && starve_q != LIMIT_C)
            starve_d = starve_q + STV_W'(1);
        else
            starve_d = starve_q;
        issued_d  = issue;
        dropped_d = (pf_hs && dup) || filt_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            issued_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clock) begin
        line_q <= line_d;
        wr_q   <= wr_d;
    end

    assign bus.pf_ready            = !full;
    assign bus.mem_req_valid       = mem_valid;
    assign bus.cpu_req_ready       = !pf_sel && bus.mem_req_ready;
    assign bus.mem_req_is_prefetch = pf_sel;
    assign bus.mem_req_bits_addr   = pf_sel ? {line_q[head_q], {LINE_SHIFT{1'b0}}}
                                            : bus.cpu_req_bits_addr;
    assign bus.mem_req_bits_tag    = pf_sel ? PF_TAG : bus.cpu_req_bits_tag;
    assign bus.mem_req_bits_cmd    = pf_sel ? (wr_q[head_q] ? M_PFW : M_PFR)
                                            : bus.cpu_req_bits_cmd;
    assign bus.stat_pf_issued      = issued_q;
    assign bus.stat_pf_dropped     = dropped_q;
endmodule

// File: tb/tb_l1_prefetch_arbiter.sv
// Bench for l1_prefetch_arbiter: directed vector table, corner-case sequences and a
// randomized run checked every cycle against a queue-based model of the arbiter.
module tb_l1_prefetch_arbiter;
    localparam int AW    = 40;
    localparam int LS    = 6;
    localparam int LW    = AW - LS;
    localparam int DEPTH = 4;
    localparam int LIMIT = 16;
    localparam logic [7:0]    PF_TAG = 8'hFF;
    localparam logic [AW-1:0] DA     = 40'h12_3456_789A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_prefetch_arbiter_if #(.ADDR_BITS(AW), .TAG_BITS(8), .CMD_BITS(5)) bus();
    l1_prefetch_arbiter dut (.clock(clk), .reset(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] cur_tag = 8'h12;
    logic [4:0] cur_cmd = 5'h01;

    // Reference model: the FIFO is a plain queue of prefetch lines.
    typedef struct {logic [LW-1:0] line; logic wr; logic vld;} ent_t;
    ent_t mq[$];
    int   m_starve;
    logic m_issued, m_dropped;

    typedef struct {
        logic mem_v, cpu_rdy, pf_rdy, is_pf;
        logic [AW-1:0] addr;
        logic [7:0] tag;
        logic [4:0] cmd;
    } exp_t;

    typedef struct {
        logic cv; logic [AW-1:0] ca; logic pv; logic [AW-1:0] pa; logic pw; logic mr;
        logic e_mv, e_cr, e_pr, e_ip; logic [AW-1:0] e_addr; logic [7:0] e_tag; logic [4:0] e_cmd;
        logic e_is, e_dr;
    } row_t;
    row_t tbl[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        logic hv;
        hv = (mq.size() > 0) && mq[0].vld;
        e.is_pf   = hv && (!bus.cpu_req_valid || m_starve == LIMIT);
        e.pf_rdy  = (mq.size() < DEPTH);
        e.mem_v   = bus.cpu_req_valid || hv;
        e.cpu_rdy = !e.is_pf && bus.mem_req_ready;
        if (e.is_pf) begin
            e.addr = {mq[0].line, 6'b0};
            e.tag  = PF_TAG;
            e.cmd  = mq[0].wr ? 5'b00011 : 5'b00010;
        end else begin
            e.addr = bus.cpu_req_bits_addr;
            e.tag  = bus.cpu_req_bits_tag;
            e.cmd  = bus.cpu_req_bits_cmd;
        end
        return e;
    endfunction

    task automatic model_check();
        exp_t e;
        e = model_outputs();
        check("m_mem_valid", bus.mem_req_valid, e.mem_v);
        check("m_cpu_ready", bus.cpu_req_ready, e.cpu_rdy);
        check("m_pf_ready", bus.pf_ready, e.pf_rdy);
        check("m_is_prefetch", bus.mem_req_is_prefetch, e.is_pf);
        check("m_stat_issued", bus.stat_pf_issued, m_issued);
        check("m_stat_dropped", bus.stat_pf_dropped, m_dropped);
        if (e.mem_v) begin
            check("m_mem_addr", bus.mem_req_bits_addr, e.addr);
            check("m_mem_tag", bus.mem_req_bits_tag, e.tag);
            check("m_mem_cmd", bus.mem_req_bits_cmd, e.cmd);
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic hv, pf_hs, dup, issue, silent, cpu_hs, cleared;
        logic [LW-1:0] pl, cl;
        e      = model_outputs();
        hv     = (mq.size() > 0) && mq[0].vld;
        pl     = bus.pf_bits_addr[AW-1:LS];
        cl     = bus.cpu_req_bits_addr[AW-1:LS];
        pf_hs  = bus.pf_valid && e.pf_rdy;
        dup    = 1'b0;
        foreach (mq[i]) if (mq[i].vld && mq[i].line == pl) dup = 1'b1;
        issue  = e.mem_v && bus.mem_req_ready && e.is_pf;
        silent = (mq.size() > 0) && !mq[0].vld;
        cpu_hs = bus.cpu_req_valid && e.cpu_rdy;
        cleared = 1'b0;
`ifdef L1_PREFETCH_DEMAND_FILTER_EN
        if (cpu_hs) foreach (mq[i]) if (mq[i].vld && mq[i].line == cl) begin
            mq[i].vld = 1'b0;
            cleared = 1'b1;
        end
`else
        if (cpu_hs && cl == '1) cleared = 1'b0;
`endif
        if (issue || !hv) m_starve = 0;
        else if (bus.cpu_req_valid && !e.is_pf && m_starve < LIMIT) m_starve++;
        if (issue || silent) void'(mq.pop_front());
        if (pf_hs && !dup) mq.push_back('{line: pl, wr: bus.pf_bits_write, vld: 1'b1});
        m_issued  = issue;
        m_dropped = (pf_hs && dup) || cleared;
        if (rst) begin
            mq.delete();
            m_starve  = 0;
            m_issued  = 1'b0;
            m_dropped = 1'b0;
        end
    endtask

    task automatic drive(input logic cv, input logic [AW-1:0] ca, input logic pv,
                         input logic [AW-1:0] pa, input logic pw, input logic mr);
        bus.cpu_req_valid     = cv;
        bus.cpu_req_bits_addr = ca;
        bus.cpu_req_bits_tag  = cur_tag;
        bus.cpu_req_bits_cmd  = cur_cmd;
        bus.pf_valid          = pv;
        bus.pf_bits_addr      = pa;
        bus.pf_bits_write     = pw;
        bus.mem_req_ready     = mr;
    endtask

    // Called 1 time unit after a rising edge; samples 2 units later, well before the next edge.
    task automatic cyc(input logic cv, input logic [AW-1:0] ca, input logic pv,
                       input logic [AW-1:0] pa, input logic pw, input logic mr);
        drive(cv, ca, pv, pa, pw, mr);
        #2;
        model_check();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mr);
        cyc(1'b0, '0, 1'b0, '0, 1'b0, mr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b1);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // cv ca pv pa pw mr | mem_v cpu_rdy pf_rdy is_pf addr tag cmd issued dropped
        tbl[0]  = '{0, 0, 0, 0, 0, 1,             0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 40'h1234, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0,             1, 0, 1, 1, 40'h1200, 8'hFF, 5'b00010, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1,             1, 0, 1, 1, 40'h1200, 8'hFF, 5'b00010, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1,             0, 1, 1, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1,             0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 40'h1000, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 40'h1038, 0, 0,      1, 0, 1, 1, 40'h1000, 8'hFF, 5'b00010, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,             1, 0, 1, 1, 40'h1000, 8'hFF, 5'b00010, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 1,             1, 0, 1, 1, 40'h1000, 8'hFF, 5'b00010, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1,             0, 1, 1, 0, 0, 0, 0, 1, 0};
        tbl[11] = '{1, DA, 0, 0, 0, 1,            1, 1, 1, 0, DA, 8'h12, 5'h01, 0, 0};
        tbl[12] = '{0, 0, 1, 40'h5_0047, 1, 1,    0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 1,             1, 0, 1, 1, 40'h5_0040, 8'hFF, 5'b00011, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 1,             0, 1, 1, 0, 0, 0, 0, 1, 0};
        tbl[15] = '{0, 0, 1, 40'h7000, 0, 1,      0, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{1, DA, 0, 0, 0, 1,            1, 1, 1, 0, DA, 8'h12, 5'h01, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 1,             1, 0, 1, 1, 40'h7000, 8'hFF, 5'b00010, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 1,             0, 1, 1, 0, 0, 0, 0, 1, 0};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_starve  = 0;
        m_issued  = 1'b0;
        m_dropped = 1'b0;

        // Directed vector table
        for (int r = 0; r < 19; r++) begin
            cyc(tbl[r].cv, tbl[r].ca, tbl[r].pv, tbl[r].pa, tbl[r].pw, tbl[r].mr);
            check($sformatf("tbl%0d_mem_valid", r), bus.mem_req_valid, tbl[r].e_mv);
            check($sformatf("tbl%0d_cpu_ready", r), bus.cpu_req_ready, tbl[r].e_cr);
            check($sformatf("tbl%0d_pf_ready", r), bus.pf_ready, tbl[r].e_pr);
            check($sformatf("tbl%0d_is_prefetch", r), bus.mem_req_is_prefetch, tbl[r].e_ip);
            check($sformatf("tbl%0d_stat_issued", r), bus.stat_pf_issued, tbl[r].e_is);
            check($sformatf("tbl%0d_stat_dropped", r), bus.stat_pf_dropped, tbl[r].e_dr);
            if (tbl[r].e_mv) begin
                check($sformatf("tbl%0d_addr", r), bus.mem_req_bits_addr, tbl[r].e_addr);
                check($sformatf("tbl%0d_tag", r), bus.mem_req_bits_tag, tbl[r].e_tag);
                check($sformatf("tbl%0d_cmd", r), bus.mem_req_bits_cmd, tbl[r].e_cmd);
            end
            tick();
        end

        // Full FIFO: fifth request held until the first dequeue completes
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1, 40'(i + 1) << 8, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, '0, 1'b1, 40'h500, 1'b0, 1'b0);
            check("full_pf_ready_low", bus.pf_ready, 1'b0);
            tick();
        end
        cyc(1'b0, '0, 1'b1, 40'h500, 1'b0, 1'b1);
        check("full_deq_cycle_pf_ready", bus.pf_ready, 1'b0);
        check("full_deq_addr", bus.mem_req_bits_addr, 40'h100);
        tick();
        cyc(1'b0, '0, 1'b1, 40'h500, 1'b0, 1'b0);
        check("full_after_deq_pf_ready", bus.pf_ready, 1'b1);
        tick();
        repeat (6) begin idle(1'b1); tick(); end

        // Starvation: 16 demand grants, then the forced prefetch
        do_reset();
        cyc(1'b0, '0, 1'b1, 40'h3000, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < LIMIT; k++) begin
            cyc(1'b1, DA, 1'b0, '0, 1'b0, 1'b1);
            check($sformatf("starve_demand%0d_cpu_ready", k), bus.cpu_req_ready, 1'b1);
            check($sformatf("starve_demand%0d_is_pf", k), bus.mem_req_is_prefetch, 1'b0);
            tick();
        end
        cyc(1'b1, DA, 1'b0, '0, 1'b0, 1'b1);
        check("starve_forced_cpu_ready", bus.cpu_req_ready, 1'b0);
        check("starve_forced_is_pf", bus.mem_req_is_prefetch, 1'b1);
        check("starve_forced_addr", bus.mem_req_bits_addr, 40'h3000);
        tick();
        cyc(1'b1, DA, 1'b1, 40'h4000, 1'b0, 1'b1);
        check("starve_after_cpu_ready", bus.cpu_req_ready, 1'b1);
        check("starve_after_issued", bus.stat_pf_issued, 1'b1);
        tick();
        cyc(1'b1, DA, 1'b0, '0, 1'b0, 1'b1);
        check("starve_cnt_cleared", bus.mem_req_is_prefetch, 1'b0);
        tick();
        repeat (3) begin idle(1'b1); tick(); end

        // Demand to a queued line
        do_reset();
        cyc(1'b0, '0, 1'b1, 40'h2000, 1'b0, 1'b0);
        tick();
        cyc(1'b1, 40'h2010, 1'b0, '0, 1'b0, 1'b1);
        check("filt_demand_hs", bus.cpu_req_ready, 1'b1);
        tick();
        idle(1'b1);
`ifdef L1_PREFETCH_DEMAND_FILTER_EN
        check("filt_no_mem_valid", bus.mem_req_valid, 1'b0);
        check("filt_dropped", bus.stat_pf_dropped, 1'b1);
`else
        check("nofilt_is_pf", bus.mem_req_is_prefetch, 1'b1);
        check("nofilt_addr", bus.mem_req_bits_addr, 40'h2000);
        check("nofilt_dropped", bus.stat_pf_dropped, 1'b0);
`endif
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
`ifdef L1_PREFETCH_DEMAND_FILTER_EN
            check($sformatf("filt_never_pf%0d", k), bus.mem_req_is_prefetch, 1'b0);
`endif
            tick();
        end

        // Reset with three entries queued and a duplicate arriving in the reset cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, 40'(i + 1) << 8, 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        cyc(1'b0, '0, 1'b1, 40'h13F, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        idle(1'b0);
        check("rst_mem_valid", bus.mem_req_valid, 1'b0);
        check("rst_pf_ready", bus.pf_ready, 1'b1);
        check("rst_stat_issued", bus.stat_pf_issued, 1'b0);
        check("rst_stat_dropped", bus.stat_pf_dropped, 1'b0);
        tick();

        // Randomized traffic on a small line pool so dedup, filtering and starvation all occur
        for (int n = 0; n < 700; n++) begin
            logic cv, pv, pw, mr;
            logic [AW-1:0] ca, pa;
            cv = (n < 350) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) != 0);
            pv = $urandom_range(0, 1) == 1;
            pw = $urandom_range(0, 1) == 1;
            mr = $urandom_range(0, 3) != 0;
            ca = (40'($urandom_range(64, 71)) << LS) | 40'($urandom_range(0, 63));
            pa = (40'($urandom_range(64, 71)) << LS) | 40'($urandom_range(0, 63));
            cur_tag = 8'($urandom_range(0, 254));
            cur_cmd = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 149) == 0);
            cyc(cv, ca, pv, pa, pw, mr);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
